// File: rtl/uacc_pkg.sv
// Shared types and width helper for the unsigned block accumulator.
package uacc_pkg;

  typedef enum logic {S_EMPTY, S_FULL} uacc_state_t;

  function automatic int uacc_acc_width(input int data_w, input int len);
    return data_w + $clog2(len);
  endfunction

endpackage

// File: rtl/uacc_out_reg.sv
// One-entry valid/ready holding register: load, hold, drain, and load+drain in one cycle.
module uacc_out_reg
  import uacc_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] dout
);

  uacc_state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      dout    <= '0;
    end else begin
      state_q <= state_d;
      if (load) dout <= din;
    end
  end

  // A load while draining keeps the register full with the new value.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (m_ready && !load) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  assign m_valid = (state_q == S_FULL);

endmodule

// File: rtl/unsigned_block_accumulator.sv
// Sums frames of ACC_LEN unsigned samples at full precision into a one-entry output register.
// Optional synchronous partial-frame clear via macro UNSIGNED_BLOCK_ACCUMULATOR_SYNC_CLEAR_EN.
module unsigned_block_accumulator
  import uacc_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int ACC_LEN    = 4,
  localparam int ACC_WIDTH  = uacc_acc_width(DATA_WIDTH, ACC_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef UNSIGNED_BLOCK_ACCUMULATOR_SYNC_CLEAR_EN
  input  logic                  clr,
`endif
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ACC_WIDTH-1:0]  dout
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  if (DATA_WIDTH <= 0) begin : g_bad_data_width
    $error("unsigned_block_accumulator: DATA_WIDTH must be > 0");
  end
  if (ACC_LEN < 1) begin : g_bad_acc_len
    $error("unsigned_block_accumulator: ACC_LEN must be >= 1");
  end

  // Reset asserts immediately but releases two edges after rst falls.
  logic rst_meta, rst_int;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  logic clr_en;
`ifdef UNSIGNED_BLOCK_ACCUMULATOR_SYNC_CLEAR_EN
  assign clr_en = clr;
`else
  assign clr_en = 1'b0;
`endif

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [CNT_W-1:0]     count;
  logic                 is_last;
  logic                 s_xfer;
  logic                 load;

  assign is_last = (count == LAST_CNT);
  assign s_ready = !rst_int && !clr_en && (!is_last || !m_valid || m_ready);
  assign s_xfer  = s_valid && s_ready;
  assign sum     = acc + ACC_WIDTH'(din);
  assign load    = s_xfer && is_last;

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      acc   <= '0;
      count <= '0;
    end else if (clr_en) begin
      acc   <= '0;
      count <= '0;
    end else if (s_xfer) begin
      if (is_last) begin
        acc   <= '0;
        count <= '0;
      end else begin
        acc   <= sum;
        count <= count + CNT_W'(1);
      end
    end
  end

  uacc_out_reg #(
    .W(ACC_WIDTH)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst_int),
    .load   (load),
    .din    (sum),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .dout   (dout)
  );

endmodule
